dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port 256x8 data memory. The memory has a combinational read and a synchronous write.
- Port 0 is the CPU load/store path. Port 1 is the DMA/loader path.
- Each accepted request becomes one registered memory access cycle. Read data returns to the requester on a registered response.
- Throughput is one access per cycle. The block sits between both requesters and the memory's A/WD/WE/RD pins.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_arbiter_if.sv | 64 ++++++
 rtl/dmem_rr_pick.sv | 37 +++
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared constants and command type for the data-memory
//                arbiter (256x8 single-port data memory).
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 8;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  // One accepted memory access, as latched into the access register.
  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
    logic                   port;
  } dmem_cmd_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_if
//  Description : Requester (port 0 CPU, port 1 DMA) and memory-pin bundle of
//                the data-memory arbiter. Compile-time option
//                DMEM_ARB_LOCK_EN adds the lock0 request qualifier.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;
`ifdef DMEM_ARB_LOCK_EN
  logic              lock0;
`endif

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rd;

  // Arbiter view: takes requests and memory read data, drives the rest.
  modport slave (
`ifdef DMEM_ARB_LOCK_EN
    input  lock0,
`endif
    input  req0, we0, addr0, wdata0,
    output gnt0, rvalid0, rdata0,
    input  req1, we1, addr1, wdata1,
    output gnt1, rvalid1, rdata1,
    output mem_a, mem_wd, mem_we,
    input  mem_rd
  );

  // Environment view: requesters plus the memory itself.
  modport master (
`ifdef DMEM_ARB_LOCK_EN
    output lock0,
`endif
    output req0, we0, addr0, wdata0,
    input  gnt0, rvalid0, rdata0,
    output req1, we1, addr1, wdata1,
    input  gnt1, rvalid1, rdata1,
    input  mem_a, mem_wd, mem_we,
    output mem_rd
  );

endinterface
`default_nettype wire

// File: rtl/dmem_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_rr_pick
//  Description : Combinational 2-way picker. Round-robin on the last winner,
//                or fixed priority to port 0 when FIXED_PRIO != 0.
//                Produces a one-hot (or zero) grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_rr_pick
  import dmem_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // On contention the port that did not win last time goes first.
  always_comb begin
    gnt_o = 2'b00;
    if (req0_i && req1_i) begin
      if ((FIXED_PRIO != 0) || (last_i == PORT_DMA)) begin
        gnt_o = 2'b01;
      end else begin
        gnt_o = 2'b10;
      end
    end else if (req0_i) begin
      gnt_o = 2'b01;
    end else if (req1_i) begin
      gnt_o = 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-requester arbiter/sequencer for a 256x8 single-port data
//                memory (combinational read, synchronous write). Accept in N,
//                memory access in N+1, read response in N+2; one access per
//                cycle. Optional macro DMEM_ARB_LOCK_EN adds lock0, which lets
//                port 0 hold off port 1 across a read-modify-write.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int FIXED_PRIO = 0
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  logic              w_req1;
  logic              w_rr_upd;
  logic [1:0]        w_gnt;
  logic              w_accept;
  logic              w_rd_done;

  dmem_cmd_t         cmd_q, cmd_d;
  logic              acc_valid_q, acc_valid_d;
  logic              last_q, last_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

`ifdef DMEM_ARB_LOCK_EN
  logic              locked_q, locked_d;

  // While locked, port 1 is invisible to the picker and grants do not move
  // the round-robin pointer.
  assign w_req1   = bus.req1 & ~locked_q;
  assign w_rr_upd = ~locked_q;

  // Every port-0 accept reloads the lock from its lock0 qualifier.
  always_comb begin
    locked_d = locked_q;
    if (w_gnt[0]) begin
      locked_d = bus.lock0;
    end
  end

  // Lock flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked_q <= 1'b0;
    end else begin
      locked_q <= locked_d;
    end
  end
`else
  assign w_req1   = bus.req1;
  assign w_rr_upd = 1'b1;
`endif

  dmem_rr_pick #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .req0_i (bus.req0),
    .req1_i (w_req1),
    .last_i (last_q),
    .gnt_o  (w_gnt)
  );

  assign bus.gnt0 = w_gnt[0];
  assign bus.gnt1 = w_gnt[1];
  assign w_accept = w_gnt[0] | w_gnt[1];

  // Latch the winner's command into the access register; track last winner.
  always_comb begin
    cmd_d       = cmd_q;
    acc_valid_d = w_accept;
    last_d      = last_q;
    if (w_gnt[0]) begin
      cmd_d.we    = bus.we0;
      cmd_d.addr  = bus.addr0;
      cmd_d.wdata = bus.wdata0;
      cmd_d.port  = PORT_CPU;
    end else if (w_gnt[1]) begin
      cmd_d.we    = bus.we1;
      cmd_d.addr  = bus.addr1;
      cmd_d.wdata = bus.wdata1;
      cmd_d.port  = PORT_DMA;
    end
    if (w_accept && w_rr_upd) begin
      last_d = cmd_d.port;
    end
  end

  // A read access captures the memory's combinational data for its owner.
  always_comb begin
    w_rd_done = acc_valid_q & ~cmd_q.we;
    rvalid0_d = w_rd_done & (cmd_q.port == PORT_CPU);
    rvalid1_d = w_rd_done & (cmd_q.port == PORT_DMA);
    rdata0_d  = rvalid0_d ? bus.mem_rd : rdata0_q;
    rdata1_d  = rvalid1_d ? bus.mem_rd : rdata1_q;
  end

  // Pipeline state; reset aborts any in-flight access and its response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q       <= '0;
      acc_valid_q <= 1'b0;
      last_q      <= PORT_DMA;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      cmd_q       <= cmd_d;
      acc_valid_q <= acc_valid_d;
      last_q      <= last_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  // Address and write data hold between accesses; only the strobe is gated.
  assign bus.mem_a   = cmd_q.addr;
  assign bus.mem_wd  = cmd_q.wdata;
  assign bus.mem_we  = acc_valid_q & cmd_q.we;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter. Two instances
//                (round-robin and fixed priority), each with its own 256x8
//                memory model. Stimulus queues the expected grant, access and
//                read data per accept; a negedge monitor checks them.
//                Lock scenario compiled only with DMEM_ARB_LOCK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
  import dmem_pkg::*;

  typedef struct packed {
    logic       port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus_a ();
  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus_b ();

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0)) u_rr (
    .clk (clk), .rst (rst), .bus (bus_a.slave)
  );
  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1)) u_fp (
    .clk (clk), .rst (rst), .bus (bus_b.slave)
  );

  // Memory models: combinational read, write on the rising edge.
  logic [7:0] mem_arr_a [256];
  logic [7:0] mem_arr_b [256];
  assign bus_a.mem_rd = mem_arr_a[bus_a.mem_a];
  assign bus_b.mem_rd = mem_arr_b[bus_b.mem_a];
  always @(posedge clk) begin
    if (bus_a.mem_we) mem_arr_a[bus_a.mem_a] <= bus_a.mem_wd;
    if (bus_b.mem_we) mem_arr_b[bus_b.mem_a] <= bus_b.mem_wd;
  end

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t acc_p  [2];
  logic acc_pv [2];
  exp_t rsp_p  [2];
  logic rsp_pv [2];

  int   errors = 0;
  int   checks = 0;
  logic end_req  = 1'b0;
  logic mon_done = 1'b0;

  function automatic exp_t mk(input logic port, input logic we, input logic [7:0] addr,
                              input logic [7:0] wdata, input logic [7:0] rdata);
    exp_t e;
    e.port = port; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    return e;
  endfunction

  task automatic chk(input string nm, input int d, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (dut%0d): got %0h, expected %0h at %0t", nm, d, act, exp, $time);
    end
  endtask

  task automatic mon_dut(input int d, input logic g0, input logic g1, input logic rv0,
                         input logic rv1, input logic [7:0] rd0, input logic [7:0] rd1,
                         input logic [7:0] ma, input logic [7:0] mwd, input logic mwe);
    exp_t e;
    logic have;
    // Response stage: read accessed last cycle answers now.
    if (rsp_pv[d]) begin
      chk("rvalid", d, 40'({rv1, rv0}), 40'(rsp_p[d].port ? 2'b10 : 2'b01));
      chk("rdata", d, 40'(rsp_p[d].port ? rd1 : rd0), 40'(rsp_p[d].rdata));
    end else begin
      chk("rvalid_idle", d, 40'({rv1, rv0}), 40'(0));
    end
    rsp_pv[d] = 1'b0;
    // Access stage: command granted last cycle is on the memory pins now.
    if (acc_pv[d]) begin
      e = acc_p[d];
      if (e.we) begin
        chk("write_access", d, 40'({mwe, ma, mwd}), 40'({1'b1, e.addr, e.wdata}));
      end else begin
        chk("read_access", d, 40'({mwe, ma}), 40'({1'b0, e.addr}));
        rsp_p[d]  = e;
        rsp_pv[d] = 1'b1;
      end
    end else begin
      chk("we_idle", d, 40'(mwe), 40'(0));
    end
    acc_pv[d] = 1'b0;
    // Grant stage.
    have = (d == 0) ? (q_a.size() != 0) : (q_b.size() != 0);
    if (have) begin
      if (d == 0) e = q_a.pop_front();
      else        e = q_b.pop_front();
      chk("grant", d, 40'({g1, g0}), 40'(e.port ? 2'b10 : 2'b01));
      acc_p[d]  = e;
      acc_pv[d] = 1'b1;
    end else begin
      chk("no_grant", d, 40'({g1, g0}), 40'(0));
    end
  endtask

  // Monitor: samples both DUTs on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_state", 0, 40'({bus_a.mem_we, bus_a.rvalid0, bus_a.rvalid1, bus_a.rdata0,
                                 bus_a.rdata1, bus_a.mem_a, bus_a.mem_wd}), 40'(0));
      chk("reset_state", 1, 40'({bus_b.mem_we, bus_b.rvalid0, bus_b.rvalid1, bus_b.rdata0,
                                 bus_b.rdata1, bus_b.mem_a, bus_b.mem_wd}), 40'(0));
      for (int i = 0; i < 2; i++) begin
        acc_pv[i] = 1'b0;
        rsp_pv[i] = 1'b0;
      end
    end else begin
      mon_dut(0, bus_a.gnt0, bus_a.gnt1, bus_a.rvalid0, bus_a.rvalid1, bus_a.rdata0,
              bus_a.rdata1, bus_a.mem_a, bus_a.mem_wd, bus_a.mem_we);
      mon_dut(1, bus_b.gnt0, bus_b.gnt1, bus_b.rvalid0, bus_b.rvalid1, bus_b.rdata0,
              bus_b.rdata1, bus_b.mem_a, bus_b.mem_wd, bus_b.mem_we);
    end
    if (end_req && !mon_done) begin
      chk("leftover_expect", 0, 40'(q_a.size()), 40'(0));
      chk("leftover_expect", 1, 40'(q_b.size()), 40'(0));
      mon_done = 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int d, input int p, input logic r, input logic w,
                     input logic [7:0] a, input logic [7:0] wd);
    if (d == 0 && p == 0) begin
      bus_a.req0 = r; bus_a.we0 = w; bus_a.addr0 = a; bus_a.wdata0 = wd;
    end else if (d == 0) begin
      bus_a.req1 = r; bus_a.we1 = w; bus_a.addr1 = a; bus_a.wdata1 = wd;
    end else if (p == 0) begin
      bus_b.req0 = r; bus_b.we0 = w; bus_b.addr0 = a; bus_b.wdata0 = wd;
    end else begin
      bus_b.req1 = r; bus_b.we1 = w; bus_b.addr1 = a; bus_b.wdata1 = wd;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_arr_a[i] = 8'h00;
      mem_arr_b[i] = 8'h00;
    end
    for (int i = 0; i < 2; i++) begin
      acc_pv[i] = 1'b0;
      rsp_pv[i] = 1'b0;
    end
    drv(0, 0, 0, 0, 8'h00, 8'h00); drv(0, 1, 0, 0, 8'h00, 8'h00);
    drv(1, 0, 0, 0, 8'h00, 8'h00); drv(1, 1, 0, 0, 8'h00, 8'h00);
`ifdef DMEM_ARB_LOCK_EN
    bus_a.lock0 = 1'b0;
    bus_b.lock0 = 1'b0;
`endif
    #2 rst = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();

    // Write mem[0x10]=0xA5 on port 0, then read it back on port 1.
    drv(0, 0, 1, 1, 8'h10, 8'hA5); q_a.push_back(mk(1'b0, 1'b1, 8'h10, 8'hA5, 8'h00));
    cyc();
    drv(0, 0, 0, 0, 8'h00, 8'h00);
    drv(0, 1, 1, 0, 8'h10, 8'h00); q_a.push_back(mk(1'b1, 1'b0, 8'h10, 8'h00, 8'hA5));
    cyc();
    drv(0, 1, 0, 0, 8'h00, 8'h00);
    repeat (3) cyc();

    // Round-robin contention for four cycles: grants 0,1,0,1.
    drv(0, 0, 1, 0, 8'h10, 8'h00);
    drv(0, 1, 1, 1, 8'h40, 8'h55);
    q_a.push_back(mk(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5));
    q_a.push_back(mk(1'b1, 1'b1, 8'h40, 8'h55, 8'h00));
    q_a.push_back(mk(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5));
    q_a.push_back(mk(1'b1, 1'b0, 8'h40, 8'h55, 8'h55));
    cyc(); cyc();
    bus_a.we1 = 1'b0;
    cyc(); cyc();
    drv(0, 0, 0, 0, 8'h00, 8'h00); drv(0, 1, 0, 0, 8'h00, 8'h00);
    repeat (3) cyc();

    // Read-after-write at the top address 0xFF.
    drv(0, 0, 1, 1, 8'hFF, 8'h3C); q_a.push_back(mk(1'b0, 1'b1, 8'hFF, 8'h3C, 8'h00));
    cyc();
    bus_a.we0 = 1'b0;              q_a.push_back(mk(1'b0, 1'b0, 8'hFF, 8'h3C, 8'h3C));
    cyc();
    drv(0, 0, 0, 0, 8'h00, 8'h00);
    repeat (3) cyc();

    // Reset during the access cycle of a write of 0x77 to 0x20.
    drv(0, 0, 1, 1, 8'h20, 8'h77); q_a.push_back(mk(1'b0, 1'b1, 8'h20, 8'h77, 8'h00));
    cyc();
    drv(0, 0, 0, 0, 8'h00, 8'h00);
    #2 rst = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    drv(0, 0, 1, 0, 8'h20, 8'h00); q_a.push_back(mk(1'b0, 1'b0, 8'h20, 8'h00, 8'h00));
    cyc();
    drv(0, 0, 0, 0, 8'h00, 8'h00);
    repeat (3) cyc();

    // Fixed priority: port 0 wins three times, port 1 only after req0 drops.
    drv(1, 0, 1, 0, 8'h00, 8'h00);
    drv(1, 1, 1, 1, 8'h01, 8'h99);
    q_b.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h00));
    q_b.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h00));
    q_b.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h00));
    repeat (3) cyc();
    drv(1, 0, 0, 0, 8'h00, 8'h00); q_b.push_back(mk(1'b1, 1'b1, 8'h01, 8'h99, 8'h00));
    cyc();
    drv(1, 1, 0, 0, 8'h00, 8'h00);
    drv(1, 0, 1, 0, 8'h01, 8'h00); q_b.push_back(mk(1'b0, 1'b0, 8'h01, 8'h00, 8'h99));
    cyc();
    // Port 1 withdraws before ever being granted: it must not be served.
    drv(1, 1, 1, 0, 8'h01, 8'h00); q_b.push_back(mk(1'b0, 1'b0, 8'h01, 8'h00, 8'h99));
    cyc();
    drv(1, 0, 0, 0, 8'h00, 8'h00); drv(1, 1, 0, 0, 8'h00, 8'h00);
    repeat (3) cyc();

`ifdef DMEM_ARB_LOCK_EN
    // Locked read-modify-write on port 0 holds port 1 off until the unlock.
    drv(0, 0, 1, 0, 8'h10, 8'h00); bus_a.lock0 = 1'b1;
    q_a.push_back(mk(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5));
    cyc();
    drv(0, 0, 0, 0, 8'h00, 8'h00); bus_a.lock0 = 1'b0;
    drv(0, 1, 1, 0, 8'h40, 8'h00);
    repeat (2) cyc();
    drv(0, 0, 1, 1, 8'h10, 8'h5A); q_a.push_back(mk(1'b0, 1'b1, 8'h10, 8'h5A, 8'h00));
    cyc();
    drv(0, 0, 0, 0, 8'h00, 8'h00); q_a.push_back(mk(1'b1, 1'b0, 8'h40, 8'h00, 8'h55));
    cyc();
    drv(0, 1, 0, 0, 8'h00, 8'h00);
    repeat (3) cyc();
`endif

    end_req = 1'b1;
    repeat (3) cyc();
    if (!mon_done) begin
      errors++;
      $display("FAIL monitor_done: got 0, expected 1");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
